rect_reader: RTL and testbench

- Reads back a rectangular region of the VGA framebuffer through a synchronous read port and compares every pixel against an expected colour.
- Reverse path of the rectangle plot path: the plot path writes bars, this block verifies them (self-check, bar-state readback).
- Sits between a control FSM (start/done handshake) and the framebuffer read port (1-cycle read latency).

---
 rtl/rect_reader_if.sv | 43 ++++
 rtl/rect_reader.sv | 162 ++++++++++++++++
 tb/tb_rect_reader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rect_reader_if.sv
// ---------------------------------------------------------------------------
// rect_reader_if : request/result and framebuffer read-port bundle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rect_reader_if #(
  parameter int COLOUR_BITS = 3
);
  logic                   start;
  logic [9:0]             x;
  logic [8:0]             y;
  logic [9:0]             width;
  logic [8:0]             height;
  logic [COLOUR_BITS-1:0] exp_colour;

  logic [9:0]             rd_x;
  logic [8:0]             rd_y;
  logic                   rd_en;
  logic [COLOUR_BITS-1:0] rd_colour;

  logic                   busy;
  logic                   done;
  logic [18:0]            match_count;
  logic [18:0]            read_count;
  logic                   all_match;
  logic                   clipped;

  // The master side is both the requester and the framebuffer.
  modport master (
    output start, x, y, width, height, exp_colour, rd_colour,
    input  rd_x, rd_y, rd_en, busy, done, match_count, read_count,
           all_match, clipped
  );

  modport slave (
    input  start, x, y, width, height, exp_colour, rd_colour,
    output rd_x, rd_y, rd_en, busy, done, match_count, read_count,
           all_match, clipped
  );
endinterface

`default_nettype wire

// File: rtl/rect_reader.sv
// ---------------------------------------------------------------------------
// rect_reader : raster-scans a framebuffer rectangle and counts colour matches.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rect_reader #(
  parameter int COLOUR_BITS = 3,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input wire logic     clock,
  input wire logic     reset,
  rect_reader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [10:0] C_SCREEN_W = 11'(SCREEN_W);
  localparam logic [9:0]  C_SCREEN_H = 10'(SCREEN_H);

  state_t                 state_q;
  logic [10:0]            x0_q, xend_q, cx_q;
  logic [9:0]             yend_q, cy_q;
  logic [COLOUR_BITS-1:0] exp_q;
  logic                   rd_en_q, rd_vld_q;
  logic [9:0]             rd_x_q;
  logic [8:0]             rd_y_q;
  logic [18:0]            match_q, read_q;
  logic                   clipped_q, busy_q, done_q;

  logic [10:0]            nx_d;
  logic [9:0]             ny_d;
  logic                   last_pix;
  logic                   next_on;
  logic                   first_on;
  logic                   zero_size;

  // Coordinates are widened by one bit so x+width-1 / y+height-1 never wrap.
  always_comb begin
    last_pix = (cx_q == xend_q) && (cy_q == yend_q);
    if (cx_q == xend_q) begin
      nx_d = x0_q;
      ny_d = cy_q + 10'd1;
    end else begin
      nx_d = cx_q + 11'd1;
      ny_d = cy_q;
    end
  end

  assign next_on   = (nx_d < C_SCREEN_W) && (ny_d < C_SCREEN_H);
  assign first_on  = ({1'b0, bus.x} < C_SCREEN_W) && ({1'b0, bus.y} < C_SCREEN_H);
  assign zero_size = (bus.width == 10'd0) || (bus.height == 9'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      xend_q    <= '0;
      cx_q      <= '0;
      yend_q    <= '0;
      cy_q      <= '0;
      exp_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      match_q   <= '0;
      read_q    <= '0;
      clipped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= rd_en_q;
      // Read data arrives one cycle after its strobe.
      if (rd_vld_q) begin
        read_q <= read_q + 19'd1;
        if (bus.rd_colour == exp_q) match_q <= match_q + 19'd1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x0_q      <= {1'b0, bus.x};
            cx_q      <= {1'b0, bus.x};
            xend_q    <= {1'b0, bus.x} + {1'b0, bus.width} - 11'd1;
            cy_q      <= {1'b0, bus.y};
            yend_q    <= {1'b0, bus.y} + {1'b0, bus.height} - 10'd1;
            exp_q     <= bus.exp_colour;
            match_q   <= '0;
            read_q    <= '0;
            clipped_q <= 1'b0;
            if (zero_size) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SCAN;
              busy_q  <= 1'b1;
              rd_en_q <= first_on;
              if (first_on) begin
                rd_x_q <= bus.x;
                rd_y_q <= bus.y;
              end else begin
                clipped_q <= 1'b1;
              end
            end
          end
        end

        S_SCAN: begin
          if (last_pix) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            cx_q    <= nx_d;
            cy_q    <= ny_d;
            rd_en_q <= next_on;
            if (next_on) begin
              rd_x_q <= nx_d[9:0];
              rd_y_q <= ny_d[8:0];
            end else begin
              clipped_q <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_x        = rd_x_q;
  assign bus.rd_y        = rd_y_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.match_count = match_q;
  assign bus.read_count  = read_q;
  assign bus.all_match   = (match_q == read_q);
  assign bus.clipped     = clipped_q;

endmodule

`default_nettype wire

// File: tb/tb_rect_reader.sv
// ---------------------------------------------------------------------------
// tb_rect_reader : directed and randomized checks of rect_reader against a
// per-pixel reference model of the rectangle scan.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rect_reader;

  localparam int CB = 3;
  localparam int SW = 640;
  localparam int SH = 480;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rect_reader_if #(.COLOUR_BITS(CB)) bus ();

  rect_reader #(
    .COLOUR_BITS(CB),
    .SCREEN_W   (SW),
    .SCREEN_H   (SH)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  typedef struct {
    int c;
    int px;
    int py;
  } ent_t;

  logic [CB-1:0] fb [SH][SW];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_ctr = 0;
  int   c0      = 0;
  ent_t obs[$];

  // Synchronous-read framebuffer.
  always @(posedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (bus.rd_en && (int'(bus.rd_x) < SW) && (int'(bus.rd_y) < SH))
      bus.rd_colour <= fb[bus.rd_y][bus.rd_x];
  end

  always @(negedge clk) begin
    if (bus.rd_en === 1'b1)
      obs.push_back('{cyc_ctr - c0, int'(bus.rd_x), int'(bus.rd_y)});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_all(input int v);
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        fb[r][c] = CB'(v);
  endtask

  task automatic run_req(input int x, input int y, input int w, input int h,
                         input int ec, input bit mid_start);
    ent_t expq[$];
    int   er = 0;
    int   em = 0;
    int   eclip = 0;
    int   done_at;
    int   cyc;
    int   bad;
    int   px;
    int   py;

    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        px = x + i;
        py = y + j;
        if (px < SW && py < SH) begin
          expq.push_back('{j * w + i + 1, px, py});
          er++;
          if (fb[py][px] == CB'(ec)) em++;
        end else begin
          eclip = 1;
        end
      end
    end
    done_at = (w * h == 0) ? 1 : w * h + 2;

    @(negedge clk);
    check("done_pulse_width", bus.done, 0);
    c0 = cyc_ctr;
    obs.delete();
    bus.start      = 1'b1;
    bus.x          = 10'(x);
    bus.y          = 9'(y);
    bus.width      = 10'(w);
    bus.height     = 9'(h);
    bus.exp_colour = CB'(ec);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mid_start && cyc == 5) begin
        bus.start      = 1'b1;
        bus.x          = 10'd3;
        bus.y          = 9'd3;
        bus.width      = 10'd2;
        bus.height     = 9'd2;
        bus.exp_colour = ~CB'(ec);
      end else begin
        bus.start = 1'b0;
      end
      if (cyc == 1) check("busy_cycle1", bus.busy, (w * h > 0) ? 1 : 0);
    end while (bus.done !== 1'b1 && cyc < 5000);
    bus.start = 1'b0;

    check("done_cycle", cyc, done_at);
    check("busy_at_done", bus.busy, 0);
    check("read_count", bus.read_count, er);
    check("match_count", bus.match_count, em);
    check("all_match", bus.all_match, (em == er) ? 1 : 0);
    check("clipped", bus.clipped, eclip);
    check("rd_strobes", obs.size(), expq.size());
    bad = 0;
    for (int k = 0; k < obs.size() && k < expq.size(); k++)
      if (obs[k].c != expq[k].c || obs[k].px != expq[k].px || obs[k].py != expq[k].py)
        bad++;
    check("rd_addr_order", bad, 0);
  endtask

  task automatic reset_mid_scan();
    int dcnt = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.x      = 10'd100;
    bus.y      = 9'd100;
    bus.width  = 10'd20;
    bus.height = 9'd20;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_read", bus.read_count, 0);
    check("rst_match", bus.match_count, 0);
    check("rst_clipped", bus.clipped, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
    end
    check("rst_no_done", dcnt, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.width      = '0;
    bus.height     = '0;
    bus.exp_colour = '0;
    bus.rd_colour  = '0;
    fill_all(0);
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_rd_en", bus.rd_en, 0);
    check("reset_rd_x", bus.rd_x, 0);
    check("reset_rd_y", bus.rd_y, 0);
    check("reset_match", bus.match_count, 0);
    check("reset_read", bus.read_count, 0);
    check("reset_all_match", bus.all_match, 1);
    check("reset_clipped", bus.clipped, 0);
    rst = 1'b0;

    for (int r = 95; r <= 104; r++)
      for (int c = 195; c <= 269; c++)
        fb[r][c] = 3'b010;
    run_req(195, 95, 75, 10, 3'b010, 1'b0);
    fb[100][200] = 3'b100;
    run_req(195, 95, 75, 10, 3'b010, 1'b0);
    run_req(630, 470, 20, 20, 3'b000, 1'b0);
    run_req(10, 10, 0, 5, 3'b000, 1'b0);
    run_req(10, 10, 5, 0, 3'b000, 1'b0);
    run_req(195, 95, 75, 10, 3'b010, 1'b1);
    reset_mid_scan();
    run_req(190, 90, 12, 8, 3'b010, 1'b0);
    run_req(1020, 500, 6, 3, 3'b000, 1'b0);

    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        fb[r][c] = ($urandom_range(0, 1) == 1) ? 3'd5 : CB'($urandom_range(0, 7));
    for (int t = 0; t < 16; t++) begin
      int rx, ry, rw, rh, re;
      rx = ($urandom_range(0, 1) == 1) ? $urandom_range(600, 660) : $urandom_range(0, 1023);
      ry = ($urandom_range(0, 1) == 1) ? $urandom_range(455, 500) : $urandom_range(0, 511);
      rw = $urandom_range(0, 24);
      rh = $urandom_range(0, 12);
      re = ($urandom_range(0, 1) == 1) ? 5 : $urandom_range(0, 7);
      run_req(rx, ry, rw, rh, re, (t % 4 == 3) && rw * rh > 8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
